// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the SR bank write controller and its arbiter.
package sr_ctrl_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HOLD_CYCLES = 1;
  localparam int DEF_MAX_RETRY   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2
  import sr_ctrl_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t ptr,
  input  logic    adv,
  output logic    gnt,
  output req_id_t gnt_id,
  output req_id_t ptr_nxt
);

  always_comb begin
    gnt = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ptr;
    end else begin
      gnt_id = req1;
    end
    // After a grant the loser gets priority on the next tie.
    ptr_nxt = (adv && gnt) ? ~gnt_id : ptr;
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Write controller for an SR flip-flop bank: arbitrates two requesters and drives S=D/R=~D pulses.
// Define SR_VERIFY_EN to build in the Q readback check with bounded retries and the err flag.
module sr_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic [WIDTH-1:0] sr_s,
  output logic [WIDTH-1:0] sr_r,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             grant_id,
  output logic             err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [HW-1:0]    hold_q, hold_d;
  req_id_t          gid_q, gid_d;
  req_id_t          ptr_q, ptr_d;
  logic [WIDTH-1:0] sr_s_q, sr_s_d, sr_r_q, sr_r_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             adv, finish;
  logic             arb_gnt;
  req_id_t          arb_id;

`ifdef SR_VERIFY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
`else
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q ^ (MAX_RETRY > 0);
`endif

  rr_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr_q),
    .adv    (adv),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .ptr_nxt(ptr_d)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    hold_d  = hold_q;
    gid_d   = gid_q;
    adv     = 1'b0;
    finish  = 1'b0;
    sr_s_d  = '0;
    sr_r_d  = '0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef SR_VERIFY_EN
    retry_d = retry_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt) begin
          adv     = 1'b1;
          gid_d   = arb_id;
          word_d  = arb_id ? data1 : data0;
          hold_d  = '0;
          state_d = ST_DRIVE;
          sr_s_d  = word_d;
          sr_r_d  = ~word_d;
        end
      end
      ST_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
`ifdef SR_VERIFY_EN
          state_d = ST_VERIFY;
`else
          finish  = 1'b1;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
          sr_s_d = word_q;
          sr_r_d = ~word_q;
        end
      end
`ifdef SR_VERIFY_EN
      ST_VERIFY: begin
        if (sr_q == word_q) begin
          finish = 1'b1;
        end else if (retry_q != RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          hold_d  = '0;
          state_d = ST_DRIVE;
          sr_s_d  = word_q;
          sr_r_d  = ~word_q;
        end else begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
      end
`endif
      ST_ACK: begin
        state_d = ST_IDLE;
`ifdef SR_VERIFY_EN
        retry_d = '0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    // Ack is decided one cycle ahead so it leaves a flop like every other output.
    if (finish) begin
      state_d = ST_ACK;
      ack0_d  = (gid_q == 1'b0);
      ack1_d  = gid_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      hold_q  <= '0;
      gid_q   <= 1'b0;
      ptr_q   <= 1'b0;
      sr_s_q  <= '0;
      sr_r_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SR_VERIFY_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      sr_s_q  <= sr_s_d;
      sr_r_q  <= sr_r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
`ifdef SR_VERIFY_EN
      retry_q <= retry_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sr_s     = sr_s_q;
  assign sr_r     = sr_r_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
`ifdef SR_VERIFY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Self-checking bench for sr_bank_ctrl: directed vector table plus multi-cycle corner sequences.
module tb_sr_bank_ctrl;

  localparam int W    = 8;
  localparam int MAXR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  // DUT A: HOLD_CYCLES = 1
  logic rst_a, req0_a, req1_a, ack0_a, ack1_a, busy_a, gid_a, err_a;
  logic [W-1:0] d0_a, d1_a, s_a, r_a, q_a;
  logic [W-1:0] bank_a = '0;
  logic [W-1:0] mask_a, flip_a;

  sr_bank_ctrl #(.WIDTH(W), .HOLD_CYCLES(1), .MAX_RETRY(MAXR)) dut_a (
    .clk(clk), .rst(rst_a),
    .req0(req0_a), .data0(d0_a), .ack0(ack0_a),
    .req1(req1_a), .data1(d1_a), .ack1(ack1_a),
    .sr_s(s_a), .sr_r(r_a), .sr_q(q_a),
    .busy(busy_a), .grant_id(gid_a), .err(err_a)
  );

  // Bank model: bits in mask_a are stuck at 0, flip_a corrupts the readback path.
  always @(posedge clk) bank_a <= ((bank_a | s_a) & ~r_a) & ~mask_a;
  assign q_a = bank_a ^ flip_a;

  // DUT B: HOLD_CYCLES = 4
  logic rst_b, req0_b, req1_b, ack0_b, ack1_b, busy_b, gid_b, err_b;
  logic [W-1:0] d0_b, d1_b, s_b, r_b, q_b;
  logic [W-1:0] bank_b = '0;

  sr_bank_ctrl #(.WIDTH(W), .HOLD_CYCLES(4), .MAX_RETRY(MAXR)) dut_b (
    .clk(clk), .rst(rst_b),
    .req0(req0_b), .data0(d0_b), .ack0(ack0_b),
    .req1(req1_b), .data1(d1_b), .ack1(ack1_b),
    .sr_s(s_b), .sr_r(r_b), .sr_q(q_b),
    .busy(busy_b), .grant_id(gid_b), .err(err_b)
  );

  always @(posedge clk) bank_b <= (bank_b | s_b) & ~r_b;
  assign q_b = bank_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S/R exclusion and idle-hold checker on both instances
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (((s_a & r_a) != '0) || (!busy_a && ((s_a | r_a) != '0))) begin
        errors++;
        $display("FAIL excl_a: s=%h r=%h busy=%b required s&r=0 and s=r=0 when idle", s_a, r_a, busy_a);
      end
      checks++;
      if (((s_b & r_b) != '0) || (!busy_b && ((s_b | r_b) != '0))) begin
        errors++;
        $display("FAIL excl_b: s=%h r=%h busy=%b required s&r=0 and s=r=0 when idle", s_b, r_b, busy_b);
      end
    end
  end

  typedef struct {
    logic       rst, r0, r1;
    logic [7:0] d0, d1;
    logic [7:0] es, er;
    logic       ea0, ea1, ebusy, egid, eerr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] es, input logic [7:0] er,
                              input logic ea0, input logic ea1, input logic ebusy,
                              input logic egid, input logic eerr);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.es = es; v.er = er; v.ea0 = ea0; v.ea1 = ea1;
    v.ebusy = ebusy; v.egid = egid; v.eerr = eerr;
    return v;
  endfunction

  task automatic reset_a();
    rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_a = 1'b0;
  endtask

  vec_t tbl[$];
  int   drives, lat, raised0, raised1, acks0, acks1;
  logic done, got_err, seen_err, seen_ack;
  logic [7:0] first_s;

  initial begin
    rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0; d0_a = '0; d1_a = '0;
    mask_a = '0; flip_a = '0;
    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; d0_b = '0; d1_b = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // rst r0 r1 d0 d1 | sr_s sr_r ack0 ack1 busy gid err
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA5, 8'h00, 8'hA5, 8'h5A, 0, 0, 1, 0, 0));
`ifdef SR_VERIFY_EN
    tbl.push_back(mk(0, 1, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0));
`endif
    tbl.push_back(mk(0, 1, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h11, 8'hEE, 0, 0, 1, 0, 0));
`ifdef SR_VERIFY_EN
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 1, 0, 0));
`endif
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h00, 8'h00, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h22, 8'hDD, 0, 0, 1, 1, 0));
`ifdef SR_VERIFY_EN
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 1, 1, 0));
`endif
      tbl.push_back(mk(0, 1, 1, 8'h11, 8'h22, 8'h00, 8'h00, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst; req0_a = tbl[i].r0; req1_a = tbl[i].r1;
      d0_a = tbl[i].d0; d1_a = tbl[i].d1;
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d_sr_ack_busy_err", i),
          {14'd0, s_a, r_a, ack0_a, ack1_a, busy_a, err_a},
          {14'd0, tbl[i].es, tbl[i].er, tbl[i].ea0, tbl[i].ea1, tbl[i].ebusy, tbl[i].eerr});
      if (tbl[i].ebusy) chk($sformatf("vec%0d_gid", i), 32'(gid_a), 32'(tbl[i].egid));
    end

`ifdef SR_VERIFY_EN
    // Bit 0 stuck at 0: every attempt fails, ack comes with err after 1+MAXR drives.
    reset_a();
    mask_a = 8'h01; d0_a = 8'h01; req0_a = 1'b1;
    drives = 0; done = 1'b0; got_err = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); @(negedge clk);
      if (s_a != '0) drives++;
      if (ack0_a) begin done = 1'b1; got_err = err_a; req0_a = 1'b0; end
    end
    chk("stuck_done", 32'(done), 32'd1);
    chk("stuck_drives", 32'(drives), 32'(1 + MAXR));
    chk("stuck_err", 32'(got_err), 32'd1);

    // Stuck bit released during the second attempt: clean ack after 2 drives.
    reset_a();
    mask_a = 8'h01; d0_a = 8'h01; req0_a = 1'b1;
    drives = 0; done = 1'b0; got_err = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); @(negedge clk);
      if (s_a != '0) drives++;
      if (drives == 2) mask_a = '0;
      if (ack0_a) begin done = 1'b1; got_err = err_a; req0_a = 1'b0; end
    end
    chk("release_done", 32'(done), 32'd1);
    chk("release_drives", 32'(drives), 32'd2);
    chk("release_err", 32'(got_err), 32'd0);
    mask_a = '0;
`endif

    // Requester 1 write of 3C; without verify the readback is corrupted to show it is ignored.
    reset_a();
`ifdef SR_VERIFY_EN
    flip_a = '0;
`else
    flip_a = 8'hFF;
`endif
    d1_a = 8'h3C; req1_a = 1'b1;
    lat = 0; done = 1'b0; seen_err = 1'b0; first_s = '0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) first_s = s_a;
      if (err_a) seen_err = 1'b1;
      if (ack1_a) begin done = 1'b1; lat = c; req1_a = 1'b0; end
    end
    chk("w3c_sr_s_cycle1", 32'(first_s), 32'h3C);
`ifdef SR_VERIFY_EN
    chk("w3c_ack_cycle", 32'(lat), 32'd3);
`else
    chk("w3c_ack_cycle", 32'(lat), 32'd2);
`endif
    chk("w3c_err", 32'(seen_err), 32'd0);
    flip_a = '0;

    // Reset in the second DRIVE cycle of a HOLD=4 write.
    rst_b = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_b = 1'b0; req0_b = 1'b1; d0_b = 8'hF0;
    @(posedge clk); @(negedge clk);
    chk("b_drive1", {23'd0, s_b, busy_b}, {23'd0, 8'hF0, 1'b1});
    @(posedge clk); @(negedge clk);
    rst_b = 1'b1; req0_b = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_b = 1'b0;
    chk("b_reset_outputs", {15'd0, s_b, r_b, ack0_b, ack1_b, busy_b, gid_b, err_b}, 32'd0);
    seen_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack0_b || ack1_b) seen_ack = 1'b1;
    end
    chk("b_no_ack_after_reset", 32'(seen_ack), 32'd0);
    req0_b = 1'b1; req1_b = 1'b1; d0_b = 8'h0F; d1_b = 8'hF0;
    @(posedge clk); @(negedge clk);
    chk("b_regrant", {22'd0, s_b, busy_b, gid_b}, {22'd0, 8'h0F, 1'b1, 1'b0});
    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_b = 1'b0;

    // Randomized traffic on DUT A; the exclusion checker runs throughout.
    reset_a();
    raised0 = 0; raised1 = 0; acks0 = 0; acks1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack0_a) begin
        chk("rand_ack0_has_req", 32'(req0_a), 32'd1);
        chk("rand_ack0_err", 32'(err_a), 32'd0);
        acks0++; req0_a = 1'b0;
      end else if (!req0_a && c < 300 && ($urandom_range(2) == 0)) begin
        d0_a = 8'($urandom); req0_a = 1'b1; raised0++;
      end
      if (ack1_a) begin
        chk("rand_ack1_has_req", 32'(req1_a), 32'd1);
        chk("rand_ack1_err", 32'(err_a), 32'd0);
        acks1++; req1_a = 1'b0;
      end else if (!req1_a && c < 300 && ($urandom_range(2) == 0)) begin
        d1_a = 8'($urandom); req1_a = 1'b1; raised1++;
      end
    end
    chk("rand_drained", {30'd0, req0_a, req1_a}, 32'd0);
    chk("rand_acks0", 32'(acks0), 32'(raised0));
    chk("rand_acks1", 32'(acks1), 32'(raised1));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
